tmr_counter: RTL and testbench
==============================

// Module: tmr_counter
// PURPOSE
//  64-bit timer counter stage driven directly by the count_en pulse of the
//  counter-control stage. Holds the counter as two 32-bit halves (CNT0/CNT1)
//  with software load, and raises a sticky compare-match interrupt.
//  Generates the registered debug halt_ack that feeds back as halt_req.
// PARAMETERS
//  DATA_W   32  width of each counter/compare half and of wdata
//  CNT_INIT 0   value loaded into the counter on reset and on timer_en 1->0
// PORTS
//  clk         in   1       system clock
//  rst_n       in   1       async active-low reset
//  timer_en    in   1       timer enable from register block
//  count_en    in   1       increment strobe from counter-control stage
//  cnt0_wr_en  in   1       SW write strobe, counter low half
//  cnt1_wr_en  in   1       SW write strobe, counter high half
//  wdata       in   DATA_W  SW write data
//  comp0       in   DATA_W  compare value, low half
//  comp1       in   DATA_W  compare value, high half
//  int_en      in   1       interrupt enable
//  int_st_clr  in   1       W1C strobe for int_st
//  dbg_mode    in   1       debug-halt permitted
//  dbg_halt    in   1       debugger halt request
//  cnt0        out  DATA_W  counter low half
//  cnt1        out  DATA_W  counter high half
//  int_st      out  1       sticky interrupt status
//  tim_int     out  1       interrupt line = int_st & int_en
//  halt_ack    out  1       registered halt acknowledge (-> counter-control halt_req)
// BEHAVIOUR
//  - Reset: {cnt1,cnt0}=CNT_INIT, int_st=0, halt_ack=0, timer_en history=0.
//  - Counter update priority per cycle (highest first):
//    1 cnt0_wr_en/cnt1_wr_en: load wdata into the selected half(s); the other
//      half is held (no carry). Both strobes together -> both halves = wdata.
//    2 timer_en falling edge (registered previous value 1, current 0): counter
//      = CNT_INIT.
//    3 timer_en & count_en & !halt_ack: counter +1 with 2*DATA_W-bit carry from
//      cnt0 into cnt1. All-ones wraps to 0, no flag.
//    4 otherwise hold.
//  - Counter value is visible on cnt0/cnt1 the cycle after the update.
//  - Match = timer_en & ({cnt1,cnt0} == {comp1,comp0}), combinational on the
//    registered counter. int_st goes to 1 the cycle after the match.
//  - int_st: set on match; cleared by int_st_clr; set wins on a same-cycle
//    set/clear. It holds when timer_en=0. It is independent of int_en.
//  - tim_int is combinational: int_st & int_en.
//  - halt_ack <= dbg_mode & dbg_halt, 1-cycle latency. While halt_ack=1 the
//    counter never increments. SW writes and the timer_en clear still apply.
//  - Deasserting timer_en during halt still clears the counter. int_st is kept.
// TESTING
//  - Reset release, timer_en=1, count_en=1 every cycle, 10 cycles -> cnt0=10,
//    cnt1=0, int_st=0.
//  - Write cnt0=32'hFFFF_FFFF, cnt1=0, then one count_en -> cnt0=0, cnt1=1.
//    Write both=all-ones, then count_en -> counter=0.
//  - comp={0,5}, count from 0 -> int_st=1 the cycle after cnt0=5. With int_en=1
//    tim_int=1. Apply int_st_clr on a match cycle -> int_st stays 1.
//  - dbg_mode=1, dbg_halt=1 -> halt_ack=1 next cycle. count_en pulses ignored
//    and the counter holds. dbg_halt=0 -> counting resumes from the held value.
//  - Counter=123, drop timer_en -> counter=CNT_INIT next cycle. Assert
//    cnt0_wr_en in the same cycle -> the write wins.
//  - Assert rst_n low mid-count with int_st=1 -> all outputs return to reset
//    values asynchronously.

Source files
------------

// File: rtl/tmr_counter.sv
// 64-bit timer counter split into two DATA_W halves, with software load,
// clear on timer disable, debug-halt freeze and a sticky compare interrupt.
module tmr_counter #(
   parameter int unsigned            DATA_W   = 32,
   parameter logic [2*DATA_W-1:0]    CNT_INIT = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              timer_en,
   input  logic              count_en,
   input  logic              cnt0_wr_en,
   input  logic              cnt1_wr_en,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] comp0,
   input  logic [DATA_W-1:0] comp1,
   input  logic              int_en,
   input  logic              int_st_clr,
   input  logic              dbg_mode,
   input  logic              dbg_halt,
   output logic [DATA_W-1:0] cnt0,
   output logic [DATA_W-1:0] cnt1,
   output logic              int_st,
   output logic              tim_int,
   output logic              halt_ack
);

   localparam int unsigned CNT_W = 2 * DATA_W;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             int_st_q;
   logic             int_st_d;
   logic             halt_ack_q;
   logic             halt_ack_d;
   logic             timer_en_q;
   logic             timer_en_d;
   logic             ten_fall_c;
   logic             match_c;

   // Timer-enable falling edge and compare match on the registered counter
   always_comb begin
      ten_fall_c = timer_en_q & ~timer_en;
      match_c    = timer_en & (cnt_q == {comp1, comp0});
   end

   // Counter next value: SW load, then disable clear, then increment, else hold
   always_comb begin
      cnt_d = cnt_q;
      if (cnt0_wr_en || cnt1_wr_en) begin
         if (cnt0_wr_en) cnt_d[DATA_W-1:0]     = wdata;
         if (cnt1_wr_en) cnt_d[CNT_W-1:DATA_W] = wdata;
      end else if (ten_fall_c) begin
         cnt_d = CNT_INIT;
      end else if (timer_en && count_en && !halt_ack_q) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Sticky status (set beats clear), halt acknowledge and enable history
   always_comb begin
      int_st_d   = int_st_q;
      if (int_st_clr) int_st_d = 1'b0;
      if (match_c)    int_st_d = 1'b1;
      halt_ack_d = dbg_mode & dbg_halt;
      timer_en_d = timer_en;
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= CNT_INIT;
         int_st_q   <= 1'b0;
         halt_ack_q <= 1'b0;
         timer_en_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         int_st_q   <= int_st_d;
         halt_ack_q <= halt_ack_d;
         timer_en_q <= timer_en_d;
      end
   end

   // Output mapping; tim_int is a combinational gate of the sticky status
   always_comb begin
      cnt0     = cnt_q[DATA_W-1:0];
      cnt1     = cnt_q[CNT_W-1:DATA_W];
      int_st   = int_st_q;
      tim_int  = int_st_q & int_en;
      halt_ack = halt_ack_q;
   end

endmodule

// File: tb/tb_tmr_counter.sv
// Bench for tmr_counter: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a 64-bit arithmetic model.
module tb_tmr_counter;

   localparam int unsigned DATA_W = 32;

   logic              clk;
   logic              rst_n;
   logic              timer_en;
   logic              count_en;
   logic              cnt0_wr_en;
   logic              cnt1_wr_en;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] comp0;
   logic [DATA_W-1:0] comp1;
   logic              int_en;
   logic              int_st_clr;
   logic              dbg_mode;
   logic              dbg_halt;
   logic [DATA_W-1:0] cnt0;
   logic [DATA_W-1:0] cnt1;
   logic              int_st;
   logic              tim_int;
   logic              halt_ack;

   int checks   = 0;
   int failures = 0;

   tmr_counter #(.DATA_W(DATA_W), .CNT_INIT('0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .timer_en   (timer_en),
      .count_en   (count_en),
      .cnt0_wr_en (cnt0_wr_en),
      .cnt1_wr_en (cnt1_wr_en),
      .wdata      (wdata),
      .comp0      (comp0),
      .comp1      (comp1),
      .int_en     (int_en),
      .int_st_clr (int_st_clr),
      .dbg_mode   (dbg_mode),
      .dbg_halt   (dbg_halt),
      .cnt0       (cnt0),
      .cnt1       (cnt1),
      .int_st     (int_st),
      .tim_int    (tim_int),
      .halt_ack   (halt_ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: the counter is one 64-bit number
   bit [63:0] m_cnt      = 64'd0;
   bit        m_int_st   = 1'b0;
   bit        m_halt     = 1'b0;
   bit        m_ten_prev = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt      = 64'd0;
         m_int_st   = 1'b0;
         m_halt     = 1'b0;
         m_ten_prev = 1'b0;
      end else begin
         bit        hit;
         bit [63:0] nxt;
         hit = timer_en && (m_cnt == {comp1, comp0});
         nxt = m_cnt;
         if (cnt0_wr_en || cnt1_wr_en) begin
            if (cnt0_wr_en) nxt = (m_cnt & 64'hFFFF_FFFF_0000_0000) | 64'(wdata);
            if (cnt1_wr_en) nxt = (nxt & 64'h0000_0000_FFFF_FFFF) | (64'(wdata) << 32);
         end else if (m_ten_prev && !timer_en) begin
            nxt = 64'd0;
         end else if (timer_en && count_en && !m_halt) begin
            nxt = m_cnt + 64'd1;
         end
         m_int_st   = hit || (m_int_st && !int_st_clr);
         m_cnt      = nxt;
         m_halt     = dbg_mode && dbg_halt;
         m_ten_prev = timer_en;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      chk("cnt0",     64'(cnt0),     64'(m_cnt[31:0]));
      chk("cnt1",     64'(cnt1),     64'(m_cnt[63:32]));
      chk("int_st",   64'(int_st),   64'(m_int_st));
      chk("tim_int",  64'(tim_int),  64'(m_int_st & int_en));
      chk("halt_ack", 64'(halt_ack), 64'(m_halt));
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      timer_en   = 1'b0;
      count_en   = 1'b0;
      cnt0_wr_en = 1'b0;
      cnt1_wr_en = 1'b0;
      wdata      = '0;
      comp0      = '0;
      comp1      = 32'h1234_5678;
      int_en     = 1'b0;
      int_st_clr = 1'b0;
      dbg_mode   = 1'b0;
      dbg_halt   = 1'b0;
      cyc(3);
      rst_n = 1'b1;
      chk("rst_cnt0", 64'(cnt0), 64'd0);
      chk("rst_cnt1", 64'(cnt1), 64'd0);
      chk("rst_int_st", 64'(int_st), 64'd0);
      chk("rst_halt_ack", 64'(halt_ack), 64'd0);

      // Ten increments from reset
      timer_en = 1'b1;
      count_en = 1'b1;
      cyc(10);
      chk("count10_cnt0", 64'(cnt0), 64'd10);
      chk("count10_cnt1", 64'(cnt1), 64'd0);
      chk("count10_int_st", 64'(int_st), 64'd0);

      // Carry from low half into high half
      count_en   = 1'b0;
      cnt0_wr_en = 1'b1;
      wdata      = 32'hFFFF_FFFF;
      cyc(1);
      cnt0_wr_en = 1'b0;
      cnt1_wr_en = 1'b1;
      wdata      = 32'h0;
      cyc(1);
      chk("wr_low_kept", 64'(cnt0), 64'hFFFF_FFFF);
      cnt1_wr_en = 1'b0;
      count_en   = 1'b1;
      cyc(1);
      count_en = 1'b0;
      chk("carry_cnt0", 64'(cnt0), 64'd0);
      chk("carry_cnt1", 64'(cnt1), 64'd1);

      // All-ones wraps to zero
      cnt0_wr_en = 1'b1;
      cnt1_wr_en = 1'b1;
      wdata      = 32'hFFFF_FFFF;
      cyc(1);
      chk("wr_both_cnt1", 64'(cnt1), 64'hFFFF_FFFF);
      cnt0_wr_en = 1'b0;
      cnt1_wr_en = 1'b0;
      count_en   = 1'b1;
      cyc(1);
      count_en = 1'b0;
      chk("wrap_cnt0", 64'(cnt0), 64'd0);
      chk("wrap_cnt1", 64'(cnt1), 64'd0);

      // Compare match on {0,5}
      comp1    = 32'd0;
      comp0    = 32'd5;
      int_en   = 1'b1;
      count_en = 1'b1;
      cyc(5);
      count_en = 1'b0;
      chk("pre_match_cnt0", 64'(cnt0), 64'd5);
      chk("pre_match_int_st", 64'(int_st), 64'd0);
      cyc(1);
      chk("match_int_st", 64'(int_st), 64'd1);
      chk("match_tim_int", 64'(tim_int), 64'd1);
      int_st_clr = 1'b1;
      cyc(1);
      chk("set_beats_clr", 64'(int_st), 64'd1);
      int_st_clr = 1'b0;
      count_en   = 1'b1;
      cyc(1);
      count_en   = 1'b0;
      int_st_clr = 1'b1;
      cyc(1);
      int_st_clr = 1'b0;
      chk("clr_int_st", 64'(int_st), 64'd0);
      chk("clr_cnt0", 64'(cnt0), 64'd6);

      // Debug halt freezes counting, resume from held value
      dbg_mode = 1'b1;
      dbg_halt = 1'b1;
      count_en = 1'b1;
      cyc(1);
      chk("halt_ack_set", 64'(halt_ack), 64'd1);
      chk("halt_first_cnt0", 64'(cnt0), 64'd7);
      cyc(3);
      chk("halt_hold_cnt0", 64'(cnt0), 64'd7);
      dbg_halt = 1'b0;
      cyc(1);
      chk("halt_ack_clr", 64'(halt_ack), 64'd0);
      chk("halt_exit_cnt0", 64'(cnt0), 64'd7);
      cyc(1);
      chk("resume_cnt0", 64'(cnt0), 64'd8);
      count_en = 1'b0;

      // Disable clears counter; a same-cycle write wins over the clear
      cnt0_wr_en = 1'b1;
      wdata      = 32'd123;
      cyc(1);
      cnt0_wr_en = 1'b0;
      timer_en   = 1'b0;
      cyc(1);
      chk("ten_clear_cnt0", 64'(cnt0), 64'd0);
      timer_en   = 1'b1;
      cnt0_wr_en = 1'b1;
      cyc(1);
      chk("reload_cnt0", 64'(cnt0), 64'd123);
      timer_en = 1'b0;
      wdata    = 32'd77;
      cyc(1);
      cnt0_wr_en = 1'b0;
      chk("wr_beats_clear", 64'(cnt0), 64'd77);
      cyc(1);
      chk("wr_then_hold", 64'(cnt0), 64'd77);

      // Disable during halt still clears
      timer_en = 1'b1;
      dbg_halt = 1'b1;
      cyc(2);
      timer_en = 1'b0;
      cyc(1);
      chk("halt_ten_clear", 64'(cnt0), 64'd0);
      dbg_halt = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         bit [63:0] tgt;
         timer_en   = ($urandom_range(0, 19) != 0);
         count_en   = ($urandom_range(0, 2) != 0);
         cnt0_wr_en = ($urandom_range(0, 29) == 0);
         cnt1_wr_en = ($urandom_range(0, 29) == 0);
         wdata      = ($urandom_range(0, 1) != 0) ? $urandom()
                                                  : 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
         int_en     = ($urandom_range(0, 1) != 0);
         int_st_clr = ($urandom_range(0, 7) == 0);
         dbg_mode   = ($urandom_range(0, 1) != 0);
         dbg_halt   = ($urandom_range(0, 3) == 0);
         if ((i % 16) == 0) begin
            tgt   = m_cnt + 64'($urandom_range(0, 4));
            comp0 = tgt[31:0];
            comp1 = tgt[63:32];
         end
         cyc(1);
      end

      // Async reset with int_st set
      timer_en   = 1'b1;
      count_en   = 1'b0;
      cnt0_wr_en = 1'b0;
      cnt1_wr_en = 1'b0;
      int_st_clr = 1'b0;
      dbg_halt   = 1'b0;
      int_en     = 1'b1;
      cnt0_wr_en = 1'b1;
      cnt1_wr_en = 1'b1;
      wdata      = 32'd42;
      cyc(1);
      cnt0_wr_en = 1'b0;
      cnt1_wr_en = 1'b0;
      comp0      = 32'd42;
      comp1      = 32'd42;
      dbg_halt   = 1'b1;
      dbg_mode   = 1'b1;
      cyc(2);
      chk("pre_rst_int_st", 64'(int_st), 64'd1);
      chk("pre_rst_cnt1", 64'(cnt1), 64'd42);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_cnt0", 64'(cnt0), 64'd0);
      chk("async_cnt1", 64'(cnt1), 64'd0);
      chk("async_int_st", 64'(int_st), 64'd0);
      chk("async_tim_int", 64'(tim_int), 64'd0);
      chk("async_halt_ack", 64'(halt_ack), 64'd0);
      cyc(2);
      rst_n = 1'b1;
      cyc(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
